// File: rtl/can_bus_pkg.sv
// ---------------------------------------------------------------------------
// can_bus_pkg
// Shared definitions for the multiplexed CAN-controller bus master:
//   - one-hot FSM state encoding for the bus cycle
//   - width of the phase down-counter
//   - legal ranges for the chip-select count and the phase lengths
//   - phaseLoad(): converts a phase length in cycles into the counter preload
// ---------------------------------------------------------------------------
package can_bus_pkg;

    localparam int PHASE_CNT_W = 4;

    localparam int NUM_CS_MIN  = 1;
    localparam int NUM_CS_MAX  = 4;
    localparam int T_PHASE_MIN = 1;
    localparam int T_PHASE_MAX = 15;

    typedef enum logic [4:0] {
        ST_IDLE = 5'b00001,
        ST_ALE  = 5'b00010,
        ST_CSU  = 5'b00100,
        ST_STRB = 5'b01000,
        ST_HOLD = 5'b10000
    } bus_state_t;

    // A phase of N cycles preloads N-1 so it ends on the cycle the counter
    // reads zero. Out-of-range lengths are clamped so the counter never wraps.
    function automatic logic [PHASE_CNT_W-1:0] phaseLoad(input int cycles);
        int c;
        c = cycles;
        if (c < T_PHASE_MIN) c = T_PHASE_MIN;
        if (c > T_PHASE_MAX) c = T_PHASE_MAX;
        return PHASE_CNT_W'(c - 1);
    endfunction

endpackage

// File: rtl/can_phase_timer.sv
// ---------------------------------------------------------------------------
// can_phase_timer
// Loadable down-counter that times one bus phase.
//   sys_clk    : clock
//   sys_reset  : synchronous active-high reset (count cleared)
//   i_load     : load i_loadVal this cycle (takes priority over counting)
//   i_loadVal  : preload value, phase length minus one
//   o_done     : high while the count is zero (last cycle of the phase)
// ---------------------------------------------------------------------------
module can_phase_timer
    import can_bus_pkg::*;
(
    input  logic                   sys_clk,
    input  logic                   sys_reset,
    input  logic                   i_load,
    input  logic [PHASE_CNT_W-1:0] i_loadVal,
    output logic                   o_done
);

    logic [PHASE_CNT_W-1:0] r_count;

    // Count down towards zero and stop there; a fresh load starts the next phase.
    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_loadVal;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/can_muxbus_master.sv
// ---------------------------------------------------------------------------
// can_muxbus_master
// Runs Intel-style multiplexed address/data bus cycles (ALE, chip-select
// setup, RD/WR strobe, hold) towards CAN controllers, one request at a time.
//   sys_clk, sys_reset           : clock, synchronous active-high reset
//   i_req_valid / o_req_ready    : request handshake (ready only in IDLE)
//   i_req_wr, i_req_cs,
//   i_req_addr, i_req_wdata      : request type, chip select, address, data
//   o_rsp_valid                  : one-cycle completion pulse
//   o_rsp_wr, o_rsp_err,
//   o_rsp_addr, o_rsp_rdata      : completed type, bad-CS flag, address, data
//   o_busy                       : FSM not in IDLE
//   can_ale, can_cs_n,
//   can_rd_n, can_wr_n           : bus control (ALE high, others active-low)
//   can_ad_o, can_ad_oe, can_ad_i: bus drive value, drive enable, bus sample
// The tristate pad itself lives above this block.
// ---------------------------------------------------------------------------
module can_muxbus_master
    import can_bus_pkg::*;
#(
    parameter int DW       = 8,
    parameter int NUM_CS   = 2,
    parameter int T_ALE    = 2,
    parameter int T_SETUP  = 1,
    parameter int T_STROBE = 2,
    parameter int T_HOLD   = 1
) (
    input  logic              sys_clk,
    input  logic              sys_reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_wr,
    input  logic [1:0]        i_req_cs,
    input  logic [DW-1:0]     i_req_addr,
    input  logic [DW-1:0]     i_req_wdata,
    output logic              o_rsp_valid,
    output logic              o_rsp_wr,
    output logic              o_rsp_err,
    output logic [DW-1:0]     o_rsp_addr,
    output logic [DW-1:0]     o_rsp_rdata,
    output logic              o_busy,
    output logic              can_ale,
    output logic [NUM_CS-1:0] can_cs_n,
    output logic              can_rd_n,
    output logic              can_wr_n,
    output logic [DW-1:0]     can_ad_o,
    output logic              can_ad_oe,
    input  logic [DW-1:0]     can_ad_i
);

    // Chip-select indices at or above this limit are rejected without a bus cycle.
    localparam int CS_LIMIT = (NUM_CS < NUM_CS_MIN) ? NUM_CS_MIN :
                              (NUM_CS > NUM_CS_MAX) ? NUM_CS_MAX : NUM_CS;

    bus_state_t             r_state;
    bus_state_t             w_stateNext;

    logic                   w_load;
    logic [PHASE_CNT_W-1:0] w_loadVal;
    logic                   w_done;
    logic                   w_accept;
    logic                   w_acceptErr;
    logic                   w_rspFire;
    logic                   w_sample;
    logic                   w_csIllegal;

    logic                   r_capWr;
    logic [1:0]             r_capCs;
    logic [DW-1:0]          r_capAddr;
    logic [DW-1:0]          r_capWdata;
    logic [DW-1:0]          r_rdData;

    logic                   w_effWr;
    logic [1:0]             w_effCs;
    logic [DW-1:0]          w_effAddr;
    logic [DW-1:0]          w_effWdata;
    logic                   w_busPhase;

    logic                   w_aleNext;
    logic [NUM_CS-1:0]      w_csNNext;
    logic                   w_rdNNext;
    logic                   w_wrNNext;
    logic [DW-1:0]          w_adNext;
    logic                   w_oeNext;

    logic                   r_rspValid;
    logic                   r_rspWr;
    logic                   r_rspErr;
    logic [DW-1:0]          r_rspAddr;
    logic [DW-1:0]          r_rspRdata;
    logic                   r_ale;
    logic [NUM_CS-1:0]      r_csN;
    logic                   r_rdN;
    logic                   r_wrN;
    logic [DW-1:0]          r_adO;
    logic                   r_adOe;

    assign w_csIllegal = (int'(i_req_cs) >= CS_LIMIT);

    can_phase_timer u_timer (
        .sys_clk   (sys_clk),
        .sys_reset (sys_reset),
        .i_load    (w_load),
        .i_loadVal (w_loadVal),
        .o_done    (w_done)
    );

    // State register.
    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic. Each phase preloads the timer on entry and leaves on
    // the cycle the timer reads zero. A bad chip select is answered from IDLE
    // without ever leaving it.
    always_comb begin
        w_stateNext = r_state;
        w_load      = 1'b0;
        w_loadVal   = '0;
        w_accept    = 1'b0;
        w_acceptErr = 1'b0;
        w_rspFire   = 1'b0;
        w_sample    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_req_valid) begin
                    w_accept = 1'b1;
                    if (w_csIllegal) begin
                        w_acceptErr = 1'b1;
                    end else begin
                        w_stateNext = ST_ALE;
                        w_load      = 1'b1;
                        w_loadVal   = phaseLoad(T_ALE);
                    end
                end
            end
            ST_ALE: begin
                if (w_done) begin
                    w_stateNext = ST_CSU;
                    w_load      = 1'b1;
                    w_loadVal   = phaseLoad(T_SETUP);
                end
            end
            ST_CSU: begin
                if (w_done) begin
                    w_stateNext = ST_STRB;
                    w_load      = 1'b1;
                    w_loadVal   = phaseLoad(T_STROBE);
                end
            end
            ST_STRB: begin
                if (w_done) begin
                    w_sample    = 1'b1;
                    w_stateNext = ST_HOLD;
                    w_load      = 1'b1;
                    w_loadVal   = phaseLoad(T_HOLD);
                end
            end
            ST_HOLD: begin
                if (w_done) begin
                    w_rspFire   = 1'b1;
                    w_stateNext = ST_IDLE;
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // Request capture; the inputs are free to change once accepted.
    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            r_capWr    <= 1'b0;
            r_capCs    <= '0;
            r_capAddr  <= '0;
            r_capWdata <= '0;
        end else if (w_accept) begin
            r_capWr    <= i_req_wr;
            r_capCs    <= i_req_cs;
            r_capAddr  <= i_req_addr;
            r_capWdata <= i_req_wdata;
        end
    end

    // The bus outputs are registered against the next state, so on the
    // accepting edge the request fields have to come straight from the inputs.
    assign w_effWr    = w_accept ? i_req_wr    : r_capWr;
    assign w_effCs    = w_accept ? i_req_cs    : r_capCs;
    assign w_effAddr  = w_accept ? i_req_addr  : r_capAddr;
    assign w_effWdata = w_accept ? i_req_wdata : r_capWdata;
    assign w_busPhase = (w_stateNext == ST_CSU) || (w_stateNext == ST_STRB) ||
                        (w_stateNext == ST_HOLD);

    // Bus values for the coming cycle. Writes keep driving data from setup
    // through hold; reads release the bus once the address has been latched.
    always_comb begin
        w_aleNext = (w_stateNext == ST_ALE);
        w_wrNNext = !((w_stateNext == ST_STRB) && w_effWr);
        w_rdNNext = !((w_stateNext == ST_STRB) && !w_effWr);
        w_oeNext  = w_aleNext || (w_busPhase && w_effWr);
        w_adNext  = '0;
        if (w_aleNext) begin
            w_adNext = w_effAddr;
        end else if (w_busPhase && w_effWr) begin
            w_adNext = w_effWdata;
        end
        w_csNNext = '1;
        for (int i = 0; i < CS_LIMIT; i++) begin
            if (w_busPhase && (w_effCs == 2'(i))) begin
                w_csNNext[i] = 1'b0;
            end
        end
    end

    // Output registers: bus drive, read sample and completion response.
    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            r_ale      <= 1'b0;
            r_csN      <= '1;
            r_rdN      <= 1'b1;
            r_wrN      <= 1'b1;
            r_adO      <= '0;
            r_adOe     <= 1'b0;
            r_rdData   <= '0;
            r_rspValid <= 1'b0;
            r_rspWr    <= 1'b0;
            r_rspErr   <= 1'b0;
            r_rspAddr  <= '0;
            r_rspRdata <= '0;
        end else begin
            r_ale      <= w_aleNext;
            r_csN      <= w_csNNext;
            r_rdN      <= w_rdNNext;
            r_wrN      <= w_wrNNext;
            r_adO      <= w_adNext;
            r_adOe     <= w_oeNext;
            r_rspValid <= w_rspFire || w_acceptErr;
            if (w_sample) begin
                r_rdData <= can_ad_i;
            end
            if (w_acceptErr) begin
                r_rspWr    <= i_req_wr;
                r_rspErr   <= 1'b1;
                r_rspAddr  <= i_req_addr;
                r_rspRdata <= '0;
            end else if (w_rspFire) begin
                r_rspWr    <= r_capWr;
                r_rspErr   <= 1'b0;
                r_rspAddr  <= r_capAddr;
                r_rspRdata <= r_capWr ? '0 : r_rdData;
            end
        end
    end

    assign o_req_ready = (r_state == ST_IDLE);
    assign o_busy      = (r_state != ST_IDLE);
    assign o_rsp_valid = r_rspValid;
    assign o_rsp_wr    = r_rspWr;
    assign o_rsp_err   = r_rspErr;
    assign o_rsp_addr  = r_rspAddr;
    assign o_rsp_rdata = r_rspRdata;
    assign can_ale     = r_ale;
    assign can_cs_n    = r_csN;
    assign can_rd_n    = r_rdN;
    assign can_wr_n    = r_wrN;
    assign can_ad_o    = r_adO;
    assign can_ad_oe   = r_adOe;

endmodule

// File: tb/tb_can_muxbus_master.sv
// ---------------------------------------------------------------------------
// tb_can_muxbus_master
// Directed bench for can_muxbus_master. Instance A uses default timing,
// instance B uses T_ALE=1, T_SETUP=3, T_STROBE=4, T_HOLD=2. Both share the
// request inputs; "sel" chooses which one the trace recorder looks at.
// ---------------------------------------------------------------------------
module tb_can_muxbus_master;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       reqValid = 1'b0;
    logic       reqWr = 1'b0;
    logic [1:0] reqCs = 2'd0;
    logic [7:0] reqAddr = 8'h00;
    logic [7:0] reqWdata = 8'h00;
    logic [7:0] busReadData = 8'h5A;
    bit         sel = 1'b0;

    logic       aReady, aRspValid, aRspWr, aRspErr, aBusy, aAle, aRdN, aWrN, aAdOe;
    logic [1:0] aCsN;
    logic [7:0] aRspAddr, aRspRdata, aAdO, aAdI;
    logic       bReady, bRspValid, bRspWr, bRspErr, bBusy, bAle, bRdN, bWrN, bAdOe;
    logic [1:0] bCsN;
    logic [7:0] bRspAddr, bRspRdata, bAdO, bAdI;

    logic       mReady, mRspValid, mRspWr, mRspErr, mBusy, mAle, mRdN, mWrN, mAdOe;
    logic [1:0] mCsN;
    logic [7:0] mRspAddr, mRspRdata, mAdO;

    int checkCount = 0;
    int passCount  = 0;

    logic       trAle[32], trRdN[32], trWrN[32], trOe[32], trBusy[32];
    logic       trRspValid[32], trRspWr[32], trRspErr[32];
    logic [1:0] trCsN[32];
    logic [7:0] trAd[32], trRspAddr[32], trRspRdata[32];

    always #5 clk = ~clk;

    // Peripheral model: drives read data only while its read strobe is low.
    assign aAdI = aRdN ? 8'h00 : busReadData;
    assign bAdI = bRdN ? 8'h00 : busReadData;

    can_muxbus_master dutA (
        .sys_clk(clk), .sys_reset(rst),
        .i_req_valid(reqValid), .o_req_ready(aReady), .i_req_wr(reqWr),
        .i_req_cs(reqCs), .i_req_addr(reqAddr), .i_req_wdata(reqWdata),
        .o_rsp_valid(aRspValid), .o_rsp_wr(aRspWr), .o_rsp_err(aRspErr),
        .o_rsp_addr(aRspAddr), .o_rsp_rdata(aRspRdata), .o_busy(aBusy),
        .can_ale(aAle), .can_cs_n(aCsN), .can_rd_n(aRdN), .can_wr_n(aWrN),
        .can_ad_o(aAdO), .can_ad_oe(aAdOe), .can_ad_i(aAdI)
    );

    can_muxbus_master #(.T_ALE(1), .T_SETUP(3), .T_STROBE(4), .T_HOLD(2)) dutB (
        .sys_clk(clk), .sys_reset(rst),
        .i_req_valid(reqValid), .o_req_ready(bReady), .i_req_wr(reqWr),
        .i_req_cs(reqCs), .i_req_addr(reqAddr), .i_req_wdata(reqWdata),
        .o_rsp_valid(bRspValid), .o_rsp_wr(bRspWr), .o_rsp_err(bRspErr),
        .o_rsp_addr(bRspAddr), .o_rsp_rdata(bRspRdata), .o_busy(bBusy),
        .can_ale(bAle), .can_cs_n(bCsN), .can_rd_n(bRdN), .can_wr_n(bWrN),
        .can_ad_o(bAdO), .can_ad_oe(bAdOe), .can_ad_i(bAdI)
    );

    // View of whichever instance is currently under test.
    always_comb begin
        mReady    = sel ? bReady    : aReady;
        mRspValid = sel ? bRspValid : aRspValid;
        mRspWr    = sel ? bRspWr    : aRspWr;
        mRspErr   = sel ? bRspErr   : aRspErr;
        mRspAddr  = sel ? bRspAddr  : aRspAddr;
        mRspRdata = sel ? bRspRdata : aRspRdata;
        mBusy     = sel ? bBusy     : aBusy;
        mAle      = sel ? bAle      : aAle;
        mCsN      = sel ? bCsN      : aCsN;
        mRdN      = sel ? bRdN      : aRdN;
        mWrN      = sel ? bWrN      : aWrN;
        mAdO      = sel ? bAdO      : aAdO;
        mAdOe     = sel ? bAdOe     : aAdOe;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Waits (bounded) for the selected instance to be ready, then presents one
    // request for a single accepting edge. Unless holdValid is set, the request
    // fields are scrambled right after acceptance to prove they were captured.
    task automatic applyStimulus(input logic wr, input logic [1:0] cs,
                                 input logic [7:0] addr, input logic [7:0] wdata,
                                 input bit holdValid);
        int waited = 0;
        @(negedge clk);
        while (!mReady && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("ready_wait", {31'b0, mReady}, 32'd1);
        reqValid = 1'b1;
        reqWr    = wr;
        reqCs    = cs;
        reqAddr  = addr;
        reqWdata = wdata;
        @(posedge clk);
        #1;
        if (!holdValid) begin
            reqValid = 1'b0;
            reqWr    = ~wr;
            reqCs    = {cs[1], ~cs[0]};
            reqAddr  = ~addr;
            reqWdata = ~wdata;
        end
    endtask

    // Records n cycles of the selected instance at falling edges; index 0 is
    // the first cycle after the accepting edge.
    task automatic captureTrace(input int n, input int dropAt);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            trAle[k]      = mAle;
            trCsN[k]      = mCsN;
            trRdN[k]      = mRdN;
            trWrN[k]      = mWrN;
            trOe[k]       = mAdOe;
            trAd[k]       = mAdO;
            trBusy[k]     = mBusy;
            trRspValid[k] = mRspValid;
            trRspWr[k]    = mRspWr;
            trRspErr[k]   = mRspErr;
            trRspAddr[k]  = mRspAddr;
            trRspRdata[k] = mRspRdata;
            if (k == dropAt) reqValid = 1'b0;
        end
    endtask

    // Checks one complete bus cycle starting at trace index base.
    task automatic analyzeTxn(input string pfx, input int base,
                              input int tA, input int tS, input int tSt, input int tH,
                              input logic wr, input int cs,
                              input logic [7:0] addr, input logic [7:0] wdata,
                              input logic [7:0] rdata);
        int total = tA + tS + tSt + tH;
        int aleLen = 0;
        int strbCnt = 0;
        int otherCnt = 0;
        int strbStart = -1;
        int rspCnt = 0;
        int hold = base + total - 1;
        int done = base + total;
        logic [1:0] csExp;
        logic strobeN, otherN;
        csExp = 2'b11;
        csExp[cs] = 1'b0;
        while (base + aleLen < 32 && trAle[base + aleLen]) aleLen++;
        for (int i = base; i < base + total; i++) begin
            strobeN = wr ? trWrN[i] : trRdN[i];
            otherN  = wr ? trRdN[i] : trWrN[i];
            if (!strobeN) begin
                strbCnt++;
                if (strbStart < 0) strbStart = i;
            end
            if (!otherN) otherCnt++;
            if (trRspValid[i]) rspCnt++;
        end
        if (strbStart < 0) strbStart = base;
        checkOutput({pfx, "_ale_len"},       aleLen, tA);
        checkOutput({pfx, "_ale_ad"},        {24'b0, trAd[base]}, {24'b0, addr});
        checkOutput({pfx, "_ale_oe"},        {31'b0, trOe[base]}, 32'd1);
        checkOutput({pfx, "_ale_cs_n"},      {30'b0, trCsN[base]}, 32'd3);
        checkOutput({pfx, "_busy"},          {31'b0, trBusy[base]}, 32'd1);
        checkOutput({pfx, "_csu_cs_n"},      {30'b0, trCsN[base + tA]}, {30'b0, csExp});
        checkOutput({pfx, "_strb_start"},    strbStart, base + tA + tS);
        checkOutput({pfx, "_strb_len"},      strbCnt, tSt);
        checkOutput({pfx, "_other_strobe"},  otherCnt, 0);
        checkOutput({pfx, "_strb_cs_n"},     {30'b0, trCsN[strbStart]}, {30'b0, csExp});
        if (wr) begin
            checkOutput({pfx, "_csu_ad"},    {24'b0, trAd[base + tA]}, {24'b0, wdata});
            checkOutput({pfx, "_strb_ad"},   {24'b0, trAd[strbStart]}, {24'b0, wdata});
            checkOutput({pfx, "_strb_oe"},   {31'b0, trOe[strbStart]}, 32'd1);
            checkOutput({pfx, "_hold_ad"},   {24'b0, trAd[hold]}, {24'b0, wdata});
            checkOutput({pfx, "_hold_oe"},   {31'b0, trOe[hold]}, 32'd1);
        end else begin
            checkOutput({pfx, "_csu_oe"},    {31'b0, trOe[base + tA]}, 32'd0);
            checkOutput({pfx, "_strb_oe"},   {31'b0, trOe[strbStart]}, 32'd0);
            checkOutput({pfx, "_hold_oe"},   {31'b0, trOe[hold]}, 32'd0);
        end
        checkOutput({pfx, "_hold_cs_n"},     {30'b0, trCsN[hold]}, {30'b0, csExp});
        checkOutput({pfx, "_hold_strobes"},  {30'b0, trWrN[hold], trRdN[hold]}, 32'd3);
        checkOutput({pfx, "_early_rsp"},     rspCnt, 0);
        checkOutput({pfx, "_rsp_valid"},     {31'b0, trRspValid[done]}, 32'd1);
        checkOutput({pfx, "_rsp_wr"},        {31'b0, trRspWr[done]}, {31'b0, wr});
        checkOutput({pfx, "_rsp_err"},       {31'b0, trRspErr[done]}, 32'd0);
        checkOutput({pfx, "_rsp_addr"},      {24'b0, trRspAddr[done]}, {24'b0, addr});
        checkOutput({pfx, "_rsp_rdata"},     {24'b0, trRspRdata[done]}, wr ? 32'd0 : {24'b0, rdata});
        checkOutput({pfx, "_idle_cs_n"},     {30'b0, trCsN[done]}, 32'd3);
        checkOutput({pfx, "_idle_oe"},       {31'b0, trOe[done]}, 32'd0);
        checkOutput({pfx, "_idle_busy"},     {31'b0, trBusy[done]}, 32'd0);
    endtask

    initial begin
        int cnt;
        $display("[TB] start");

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_ready",  {31'b0, aReady}, 32'd1);
        checkOutput("rst_busy",   {31'b0, aBusy}, 32'd0);
        checkOutput("rst_ale",    {31'b0, aAle}, 32'd0);
        checkOutput("rst_cs_n",   {30'b0, aCsN}, 32'd3);
        checkOutput("rst_strobe", {30'b0, aRdN, aWrN}, 32'd3);
        checkOutput("rst_oe",     {31'b0, aAdOe}, 32'd0);
        checkOutput("rst_ad",     {24'b0, aAdO}, 32'd0);
        checkOutput("rst_rsp",    {29'b0, aRspValid, aRspWr, aRspErr}, 32'd0);
        checkOutput("rst_rsp_dat", {16'b0, aRspAddr, aRspRdata}, 32'd0);

        // Default timing write to chip select 1.
        sel = 1'b0;
        applyStimulus(1'b1, 2'd1, 8'h12, 8'hA5, 1'b0);
        captureTrace(9, -1);
        analyzeTxn("a_wr", 0, 2, 1, 2, 1, 1'b1, 1, 8'h12, 8'hA5, 8'h00);

        // Default timing read from chip select 0.
        busReadData = 8'h5A;
        applyStimulus(1'b0, 2'd0, 8'h34, 8'h00, 1'b0);
        captureTrace(9, -1);
        analyzeTxn("a_rd", 0, 2, 1, 2, 1, 1'b0, 0, 8'h34, 8'h00, 8'h5A);

        // Chip select out of range: no bus activity, error response next cycle.
        applyStimulus(1'b1, 2'd3, 8'h77, 8'h88, 1'b0);
        captureTrace(8, -1);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (trAle[i] || trCsN[i] != 2'b11 || !trWrN[i] || !trRdN[i]) cnt++;
        end
        checkOutput("bad_cs_bus_quiet", cnt, 0);
        checkOutput("bad_cs_rsp_valid", {31'b0, trRspValid[0]}, 32'd1);
        checkOutput("bad_cs_rsp_err",   {31'b0, trRspErr[0]}, 32'd1);
        checkOutput("bad_cs_rsp_rdata", {24'b0, trRspRdata[0]}, 32'd0);
        checkOutput("bad_cs_busy",      {31'b0, trBusy[0]}, 32'd0);
        checkOutput("bad_cs_pulse_end", {31'b0, trRspValid[1]}, 32'd0);

        // Back-to-back: valid held, second request queued behind the first.
        busReadData = 8'hC3;
        applyStimulus(1'b1, 2'd0, 8'h21, 8'h3C, 1'b1);
        reqWr    = 1'b0;
        reqCs    = 2'd1;
        reqAddr  = 8'h43;
        reqWdata = 8'hEE;
        captureTrace(16, 7);
        checkOutput("b2b_gap_no_ale", {31'b0, trAle[6]}, 32'd0);
        analyzeTxn("b2b_1", 0, 2, 1, 2, 1, 1'b1, 0, 8'h21, 8'h3C, 8'h00);
        analyzeTxn("b2b_2", 7, 2, 1, 2, 1, 1'b0, 1, 8'h43, 8'hEE, 8'hC3);

        // Reset during the strobe of a write aborts cleanly.
        applyStimulus(1'b1, 2'd1, 8'h55, 8'h66, 1'b0);
        repeat (4) @(negedge clk);
        checkOutput("abort_in_strobe", {31'b0, aWrN}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_strobes", {30'b0, aRdN, aWrN}, 32'd3);
        checkOutput("abort_cs_n",    {30'b0, aCsN}, 32'd3);
        checkOutput("abort_oe",      {31'b0, aAdOe}, 32'd0);
        checkOutput("abort_ready",   {31'b0, aReady}, 32'd1);
        cnt = aRspValid ? 1 : 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (aRspValid) cnt++;
        end
        checkOutput("abort_no_rsp", cnt, 0);
        busReadData = 8'h9E;
        applyStimulus(1'b0, 2'd1, 8'h0F, 8'h00, 1'b0);
        captureTrace(9, -1);
        analyzeTxn("post_rst_rd", 0, 2, 1, 2, 1, 1'b0, 1, 8'h0F, 8'h00, 8'h9E);

        // Stretched timing instance.
        sel = 1'b1;
        applyStimulus(1'b1, 2'd0, 8'hB4, 8'h4B, 1'b0);
        captureTrace(14, -1);
        analyzeTxn("t_wr", 0, 1, 3, 4, 2, 1'b1, 0, 8'hB4, 8'h4B, 8'h00);
        busReadData = 8'h2D;
        applyStimulus(1'b0, 2'd1, 8'hE1, 8'h00, 1'b0);
        captureTrace(14, -1);
        analyzeTxn("t_rd", 0, 1, 3, 4, 2, 1'b0, 1, 8'hE1, 8'h00, 8'h2D);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/can_muxbus_master.md
CAN_MUXBUS_MASTER -- requirements
Module: can_muxbus_master

Interface
REQ-001 The block SHALL have parameter DW, default 8: width of the multiplexed address/data bus and of the user address and data.
REQ-002 The block SHALL have parameter NUM_CS, default 2: number of chip-select lines, legal range 1..4.
REQ-003 The block SHALL have parameters T_ALE, T_SETUP, T_STROBE, T_HOLD, defaults 2, 1, 2, 1: phase lengths in sys_clk cycles, each legal range 1..15.
REQ-004 sys_clk  in  1  single clock for all logic.
REQ-005 sys_reset  in  1  reset, synchronous, active-high.
REQ-006 i_req_valid  in  1  request present.
REQ-007 o_req_ready  out  1  request accepted when i_req_valid and o_req_ready are both high at a rising edge.
REQ-008 i_req_wr  in  1  1 = write, 0 = read.
REQ-009 i_req_cs  in  2  target chip-select index.
REQ-010 i_req_addr, i_req_wdata  in  DW each  register address and write data.
REQ-011 o_rsp_valid  out  1  one-cycle pulse: transaction complete.
REQ-012 o_rsp_wr, o_rsp_err  out  1 each  completed type; illegal-CS error flag.
REQ-013 o_rsp_addr, o_rsp_rdata  out  DW each  completed address; read data (0 for writes).
REQ-014 o_busy  out  1  high whenever the FSM is not in IDLE.
REQ-015 can_ale  out  1  address latch enable, active-high.
REQ-016 can_cs_n  out  NUM_CS  chip selects, active-low.
REQ-017 can_rd_n, can_wr_n  out  1 each  read and write strobes, active-low.
REQ-018 can_ad_o  out  DW  bus drive value; can_ad_oe  out  1  drive enable; can_ad_i  in  DW  bus sample. The tristate buffer lives at top level, not in this block.

Function
REQ-019 All bus and response outputs SHALL be registered.
REQ-020 The FSM SHALL have states IDLE, ALE, CSU, STRB, HOLD, and o_req_ready SHALL equal (state==IDLE).
REQ-021 On acceptance the block SHALL capture wr, cs, addr and wdata, and SHALL ignore later changes on the i_req_* inputs until the next acceptance.
REQ-022 ALE: entered the cycle after acceptance; lasts T_ALE cycles; can_ale=1, can_ad_oe=1, can_ad_o=addr, all strobes and CS high.
REQ-023 CSU: lasts T_SETUP cycles; can_ale=0 and the selected can_cs_n bit low. A write drives can_ad_o=wdata with can_ad_oe=1; a read sets can_ad_oe=0.
REQ-024 STRB: lasts T_STROBE cycles; can_wr_n (write) or can_rd_n (read) low; CS stays low; write data stays driven.
REQ-025 A read SHALL sample can_ad_i on the rising edge that ends the last STRB cycle.
REQ-026 HOLD: lasts T_HOLD cycles; strobe high, CS low, write data held with oe=1. A read keeps oe=0.
REQ-027 After HOLD the FSM SHALL return to IDLE, deassert CS and set oe=0. o_rsp_valid SHALL pulse for exactly that first IDLE cycle, with o_rsp_* valid in the same cycle.
REQ-028 Transaction length SHALL be T_ALE+T_SETUP+T_STROBE+T_HOLD cycles, with a minimum of one IDLE cycle between transactions (bus turnaround).
REQ-029 If i_req_cs >= NUM_CS at acceptance, the block SHALL run no bus cycle: it SHALL go to IDLE and pulse o_rsp_valid with o_rsp_err=1 and o_rsp_rdata=0 on the cycle after acceptance.
REQ-030 Phase counting SHALL use a 4-bit down-counter loaded with T_x-1 on phase entry; the phase exits when the counter reaches 0. There SHALL be no wrap-around.
REQ-031 Acceptance in the same cycle as the o_rsp_valid pulse SHALL be allowed.

Reset
REQ-032 On sys_reset the block SHALL set: state=IDLE, can_ale=0, can_cs_n=all ones, can_rd_n=1, can_wr_n=1, can_ad_oe=0, can_ad_o=0, o_rsp_*=0, o_busy=0, o_req_ready=1 after the reset edge.
REQ-033 Reset mid-transaction SHALL abort at the next edge with no o_rsp_valid pulse.

Structure
REQ-034 Package can_bus_pkg SHALL hold the FSM state encoding (one-hot, 5 states), the phase-counter width constant (4) and the parameter range limits.
REQ-035 One sub-module, can_phase_timer, SHALL implement the loadable 4-bit down-counter with a done flag.

Verification
REQ-036 Defaults; write cs=1, addr=0x12, data=0xA5 -> ALE 2 cycles with AD=0x12; cs_n=2'b01; wr_n low 2 cycles with AD=0xA5; rsp pulse 6 cycles after bus start; rsp_wr=1.
REQ-037 Read cs=0, addr=0x34, bus model drives 0x5A during STRB -> rd_n low 2 cycles; oe=0 from CSU onward; rsp_rdata=0x5A; rsp_addr=0x34.
REQ-038 i_req_cs=3 with NUM_CS=2 -> no ALE/CS activity; rsp_valid with rsp_err=1 one cycle after acceptance.
REQ-039 Back-to-back requests with valid held high -> second ALE begins exactly one IDLE cycle after first HOLD; both responses correct.
REQ-040 sys_reset asserted during STRB of a write -> next cycle all strobes and CS high, oe=0, no rsp pulse; a following read completes normally.
REQ-041 Parameters T_ALE=1, T_SETUP=3, T_STROBE=4, T_HOLD=2 -> each phase length matches exactly, total 10 cycles.
